// File: rtl/jtkiwi_shram_arb.sv
// Arbitrates one single-port comm RAM between the main CPU and the sub CPU.
// Optional contention statistics are built when JTKIWI_SHRAM_STATS_EN is defined.
module jtkiwi_shram_arb #(
  parameter int AW       = 13,
  parameter int DW       = 8,
  parameter int SUB_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          main_cs,
  input  logic          main_we,
  input  logic [AW-1:0] main_addr,
  input  logic [DW-1:0] main_din,
  output logic [DW-1:0] main_dout,
  output logic          main_busy,
  input  logic          sub_cs,
  input  logic          sub_we,
  input  logic [AW-1:0] sub_addr,
  input  logic [DW-1:0] sub_din,
  output logic [DW-1:0] sub_dout,
  output logic          sub_busy,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout,
  output logic [15:0]   stall_cnt
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  localparam logic OWN_MAIN = 1'b0;
  localparam logic OWN_SUB  = 1'b1;

  state_t        state_q;
  logic          owner_q, last_q;
  logic          done_main_q, done_sub_q;
  logic          rd_q;
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_din_q;
  logic [DW-1:0] main_dout_q, sub_dout_q;

  logic          act_main, act_sub, pend_main, pend_sub, pick_sub;
  logic          own_cs, own_we;
  logic [AW-1:0] own_addr;
  logic [DW-1:0] own_din;

  assign main_busy = main_cs & ~done_main_q;
  assign sub_busy  = sub_cs  & ~done_sub_q;
  assign act_main  = (state_q != IDLE) & (owner_q == OWN_MAIN);
  assign act_sub   = (state_q != IDLE) & (owner_q == OWN_SUB);
  assign pend_main = main_busy & ~act_main;
  assign pend_sub  = sub_busy  & ~act_sub;
  // Round-robin: whoever was served last loses a tie
  assign pick_sub  = (SUB_PRIO != 0) ? 1'b1 : (last_q == OWN_MAIN);

  assign own_cs   = (owner_q == OWN_SUB) ? sub_cs   : main_cs;
  assign own_we   = (owner_q == OWN_SUB) ? sub_we   : main_we;
  assign own_addr = (owner_q == OWN_SUB) ? sub_addr : main_addr;
  assign own_din  = (owner_q == OWN_SUB) ? sub_din  : main_din;

  // RAM side follows the owner's live bus during ADDR and holds otherwise
  assign ram_we    = (state_q == ADDR) & own_we & own_cs;
  assign ram_addr  = (state_q == ADDR) ? own_addr : ram_addr_q;
  assign ram_din   = (state_q == ADDR) ? own_din  : ram_din_q;
  assign main_dout = main_dout_q;
  assign sub_dout  = sub_dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_MAIN;
      last_q      <= OWN_MAIN;
      done_main_q <= 1'b0;
      done_sub_q  <= 1'b0;
      rd_q        <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      main_dout_q <= '0;
      sub_dout_q  <= '0;
    end else begin
      if (!main_cs) done_main_q <= 1'b0;
      if (!sub_cs)  done_sub_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pend_main && pend_sub) begin
            owner_q <= pick_sub;
            state_q <= ADDR;
          end else if (pend_main) begin
            owner_q <= OWN_MAIN;
            state_q <= ADDR;
          end else if (pend_sub) begin
            owner_q <= OWN_SUB;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          ram_addr_q <= own_addr;
          ram_din_q  <= own_din;
          rd_q       <= ~(own_we & own_cs);
          state_q    <= DATA;
        end
        DATA: begin
          last_q <= owner_q;
          if (owner_q == OWN_SUB) begin
            if (rd_q) sub_dout_q <= ram_dout;
            done_sub_q <= sub_cs;
          end else begin
            if (rd_q) main_dout_q <= ram_dout;
            done_main_q <= main_cs;
          end
          // Hand straight over to a waiting requester without an idle cycle
          if ((owner_q == OWN_SUB) ? pend_main : pend_sub) begin
            owner_q <= ~owner_q;
            state_q <= ADDR;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef JTKIWI_SHRAM_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (main_busy && sub_busy && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
